// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller between a CPU word port and a
// line-wide memory port, with saturating hit/miss counters.
module dm_cache_ctrl #(
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned CACHE_SIZE      = 1024,
    parameter int unsigned CACHE_LINE_SIZE = 128,
    parameter int unsigned MEMORY_SIZE     = 65536,
    localparam int unsigned ADDR_LENGTH    = $clog2(MEMORY_SIZE)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_LENGTH-1:0]     cpu_addr,
    input  logic [WORD_SIZE-1:0]       cpu_wdata,
    output logic [WORD_SIZE-1:0]       cpu_rdata,
    output logic                       cpu_ready,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_LENGTH-1:0]     mem_addr,
    output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
    input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
    input  logic                       mem_ack,
    output logic [31:0]                hit_count,
    output logic [31:0]                miss_count
);

    localparam int unsigned NUM_LINES      = CACHE_SIZE * 8 / CACHE_LINE_SIZE;
    localparam int unsigned INDEX_LENGTH   = $clog2(NUM_LINES);
    localparam int unsigned OFFSET_LENGTH  = $clog2(CACHE_LINE_SIZE / 8);
    localparam int unsigned TAG_LENGTH     = ADDR_LENGTH - INDEX_LENGTH - OFFSET_LENGTH;
    localparam int unsigned WORD_OFFSET    = $clog2(WORD_SIZE / 8);
    localparam int unsigned WORDS_PER_LINE = CACHE_LINE_SIZE / WORD_SIZE;
    localparam int unsigned WSEL_LENGTH    = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StCompare,
        StWriteback,
        StAllocate
    } state_e;

    state_e                   state_q, state_d;
    logic                     req_we_q, req_we_d;
    logic [ADDR_LENGTH-1:0]   req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0]     req_wdata_q, req_wdata_d;
    logic                     first_q, first_d;
    logic                     cpu_ready_q, cpu_ready_d;
    logic [WORD_SIZE-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [31:0]              hit_q, hit_d;
    logic [31:0]              miss_q, miss_d;
    logic [NUM_LINES-1:0]     valid_q, valid_d;
    logic [NUM_LINES-1:0]     dirty_q, dirty_d;

    // Tag and data arrays carry no reset; valid gates every use of them.
    logic [TAG_LENGTH-1:0]      tag_q  [NUM_LINES];
    logic [CACHE_LINE_SIZE-1:0] data_q [NUM_LINES];

    logic [TAG_LENGTH-1:0]      req_tag;
    logic [INDEX_LENGTH-1:0]    req_index;
    logic [WSEL_LENGTH-1:0]     word_sel;
    logic [CACHE_LINE_SIZE-1:0] cur_line;
    logic                       line_hit;
    logic                       fill_en;
    logic                       wr_en;
    logic                       unused_addr_bits;

    assign req_tag          = req_addr_q[ADDR_LENGTH-1 -: TAG_LENGTH];
    assign req_index        = req_addr_q[OFFSET_LENGTH +: INDEX_LENGTH];
    assign cur_line         = data_q[req_index];
    assign line_hit         = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign unused_addr_bits = ^req_addr_q[WORD_OFFSET-1:0];

    if (WORDS_PER_LINE > 1) begin : g_wsel
        assign word_sel = req_addr_q[OFFSET_LENGTH-1:WORD_OFFSET];
    end else begin : g_wsel_single
        assign word_sel = '0;
    end

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        first_d     = first_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        fill_en     = 1'b0;
        wr_en       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    first_d     = 1'b1;
                    state_d     = StCompare;
                end
            end
            StCompare: begin
                first_d = 1'b0;
                if (line_hit) begin
                    // Only the first lookup of a request counts; the post-fill lookup is silent.
                    if (first_q && (hit_q != '1)) begin
                        hit_d = hit_q + 32'd1;
                    end
                    if (req_we_q) begin
                        wr_en              = 1'b1;
                        dirty_d[req_index] = 1'b1;
                    end else begin
                        cpu_rdata_d = cur_line[word_sel * WORD_SIZE +: WORD_SIZE];
                    end
                    cpu_ready_d = 1'b1;
                    state_d     = StIdle;
                end else begin
                    if (first_q && (miss_q != '1)) begin
                        miss_d = miss_q + 32'd1;
                    end
                    if (valid_q[req_index] && dirty_q[req_index]) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StAllocate;
                    end
                end
            end
            StWriteback: begin
                if (mem_ack) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                if (mem_ack) begin
                    fill_en            = 1'b1;
                    valid_d[req_index] = 1'b1;
                    dirty_d[req_index] = 1'b0;
                    state_d            = StCompare;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Memory-side outputs decode straight from state so a reset drops them immediately.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state_q)
            StWriteback: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_q[req_index], req_index, {OFFSET_LENGTH{1'b0}}};
                mem_wdata = cur_line;
            end
            StAllocate: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_index, {OFFSET_LENGTH{1'b0}}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            first_q     <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            first_q     <= first_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) begin
            data_q[req_index] <= mem_rdata;
            tag_q[req_index]  <= req_tag;
        end else if (wr_en) begin
            data_q[req_index][word_sel * WORD_SIZE +: WORD_SIZE] <= req_wdata_q;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Directed bench for dm_cache_ctrl: fills, hits, dirty/clean eviction, delayed ack, mid-fill reset.
module tb_dm_cache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic         cpu_we;
    logic [15:0]  cpu_addr;
    logic [31:0]  cpu_wdata;
    logic [31:0]  cpu_rdata;
    logic         cpu_ready;
    logic         mem_req;
    logic         mem_we;
    logic [15:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] LINE0 = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] LINE0M = 128'hA3A3A3A3_A2A2A2A2_DEADBEEF_A0A0A0A0;
    localparam logic [127:0] LINE1 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] LINE2 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    localparam logic [127:0] LINE3 = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    localparam logic [127:0] LINE4 = 128'hE3E3E3E3_E2E2E2E2_E1E1E1E1_E0E0E0E0;

    dm_cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge, away from the active edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic request(input logic we, input logic [15:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        step();
        cpu_req   = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        step();
        chk("rst_ready", cpu_ready, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_hit", hit_count, 0);
        chk("rst_miss", miss_count, 0);
        rst = 1'b0;
        step();

        // Clean cold miss on 0x0104.
        request(1'b0, 16'h0104, 32'h0);
        chk("m1_cmp_mem_req", mem_req, 0);
        chk("m1_cmp_mem_addr", mem_addr, 0);
        step();
        chk("m1_alloc_req", mem_req, 1);
        chk("m1_alloc_we", mem_we, 0);
        chk("m1_alloc_addr", mem_addr, 16'h0100);
        chk("m1_miss", miss_count, 1);
        mem_ack   = 1'b1;
        mem_rdata = LINE0;
        step();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        chk("m1_cmp2_ready", cpu_ready, 0);
        chk("m1_cmp2_mem_req", mem_req, 0);
        step();
        chk("m1_ready", cpu_ready, 1);
        chk("m1_rdata", cpu_rdata, 32'hA1A1A1A1);
        chk("m1_miss_after", miss_count, 1);
        chk("m1_hit_after", hit_count, 0);

        // Read hit on 0x0108.
        request(1'b0, 16'h0108, 32'h0);
        chk("h1_ready_early", cpu_ready, 0);
        chk("h1_mem_req", mem_req, 0);
        step();
        chk("h1_ready", cpu_ready, 1);
        chk("h1_rdata", cpu_rdata, 32'hA2A2A2A2);
        chk("h1_hit", hit_count, 1);

        // Write hit 0x0104, then back-to-back read 0x0504 forcing a dirty eviction.
        request(1'b1, 16'h0104, 32'hDEADBEEF);
        step();
        chk("w1_ready", cpu_ready, 1);
        chk("w1_hit", hit_count, 2);
        chk("w1_rdata_held", cpu_rdata, 32'hA2A2A2A2);
        request(1'b0, 16'h0504, 32'h0);
        chk("d1_cmp_ready", cpu_ready, 0);
        step();
        chk("d1_wb_req", mem_req, 1);
        chk("d1_wb_we", mem_we, 1);
        chk("d1_wb_addr", mem_addr, 16'h0100);
        chk("d1_wb_wdata", mem_wdata, LINE0M);
        chk("d1_miss", miss_count, 2);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("d1_alloc_req", mem_req, 1);
        chk("d1_alloc_we", mem_we, 0);
        chk("d1_alloc_addr", mem_addr, 16'h0500);
        chk("d1_alloc_wdata", mem_wdata, 0);
        mem_ack   = 1'b1;
        mem_rdata = LINE1;
        step();
        mem_ack   = 1'b0;
        step();
        chk("d1_ready", cpu_ready, 1);
        chk("d1_rdata", cpu_rdata, 32'hB1B1B1B1);
        chk("d1_hit", hit_count, 2);
        chk("d1_miss_after", miss_count, 2);

        // Clean fill of 0x0200, then clean eviction by 0x0600 with a slow ack.
        request(1'b0, 16'h0200, 32'h0);
        step();
        chk("c1_alloc_we", mem_we, 0);
        chk("c1_alloc_addr", mem_addr, 16'h0200);
        mem_ack   = 1'b1;
        mem_rdata = LINE2;
        step();
        mem_ack   = 1'b0;
        step();
        chk("c1_rdata", cpu_rdata, 32'hC0C0C0C0);
        request(1'b0, 16'h0600, 32'h0);
        step();
        chk("c2_no_wb_req", mem_req, 1);
        chk("c2_no_wb_we", mem_we, 0);
        chk("c2_alloc_addr", mem_addr, 16'h0600);
        chk("c2_miss", miss_count, 4);
        for (int i = 0; i < 5; i++) begin
            cpu_req  = (i == 2);
            cpu_addr = (i == 2) ? 16'h0104 : 16'h0600;
            step();
            chk("slow_req", mem_req, 1);
            chk("slow_addr", mem_addr, 16'h0600);
            chk("slow_ready", cpu_ready, 0);
        end
        cpu_req   = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = LINE3;
        step();
        mem_ack   = 1'b0;
        step();
        chk("c2_ready", cpu_ready, 1);
        chk("c2_rdata", cpu_rdata, 32'hD0D0D0D0);
        step();
        chk("c2_single_pulse", cpu_ready, 0);
        step();
        chk("c2_no_extra_ready", cpu_ready, 0);
        chk("c2_no_extra_mem", mem_req, 0);
        chk("c2_hit_final", hit_count, 2);
        chk("c2_miss_final", miss_count, 4);

        // Reset in the middle of a fill, then re-read a previously valid line.
        request(1'b0, 16'h0104, 32'h0);
        step();
        chk("r1_alloc_req", mem_req, 1);
        #1 rst = 1'b1;
        #1;
        chk("r1_req_drop", mem_req, 0);
        chk("r1_addr_drop", mem_addr, 0);
        chk("r1_miss_clr", miss_count, 0);
        step();
        rst = 1'b0;
        step();
        request(1'b0, 16'h0604, 32'h0);
        step();
        chk("r2_refill_req", mem_req, 1);
        chk("r2_refill_addr", mem_addr, 16'h0600);
        chk("r2_miss", miss_count, 1);
        mem_ack   = 1'b1;
        mem_rdata = LINE4;
        step();
        mem_ack   = 1'b0;
        step();
        chk("r2_ready", cpu_ready, 1);
        chk("r2_rdata", cpu_rdata, 32'hE1E1E1E1);
        chk("r2_hit", hit_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
